// File: rtl/branch_predict_unit_pkg.sv
// Shared branch-type codes, counter init value and small helpers for the branch predict unit.
package branch_predict_unit_pkg;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  localparam logic [1:0] CTR_WEAK_T = 2'b10;

  // Code 3'd7 is unassigned and behaves like NOBRANCH.
  function automatic logic is_branch(input logic [2:0] t);
    return (t != 3'd0) && (t != 3'd7);
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_compare.sv
// Combinational RV32I branch condition evaluation; unknown type codes never take.
module branch_compare
  import branch_predict_unit_pkg::*;
(
  input  logic [2:0]  br_type,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BEQ:     taken = (op_a == op_b);
      BNE:     taken = (op_a != op_b);
      BLT:     taken = ($signed(op_a) < $signed(op_b));
      BLTU:    taken = (op_a < op_b);
      BGE:     taken = ($signed(op_a) >= $signed(op_b));
      BGEU:    taken = (op_a >= op_b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB/BHT lookup in IF, branch resolution and table training in EX.
// Lookup is combinational from pre-update state; trained entries are visible the cycle after.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter bit PRED_EN = 1'b1
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        ValidE,
  input  logic [2:0]  BranchTypeE,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        BranchE,
  output logic        MispredE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = 30 - IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [1:0]       ctr_q [DEPTH];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic             br_valid, cmp_taken;
  logic             unused_pc_lsb;

  assign f_idx = PCF[IDX_W+1:2];
  assign f_tag = PCF[31:IDX_W+2];
  assign e_idx = PCE[IDX_W+1:2];
  assign e_tag = PCE[31:IDX_W+2];
  assign unused_pc_lsb = ^{PCF[1:0], PCE[1:0]};

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

  assign PredTakenF  = PRED_EN && CPU_RST_N && f_hit && ctr_q[f_idx][1];
  assign PredTargetF = PredTakenF ? tgt_q[f_idx] : PCF + 32'd4;

  branch_compare u_cmp (
    .br_type (BranchTypeE),
    .op_a    (Operand1),
    .op_b    (Operand2),
    .taken   (cmp_taken)
  );

  assign br_valid    = CPU_RST_N && ValidE && is_branch(BranchTypeE);
  assign BranchE     = br_valid && cmp_taken;
  assign RedirectPCE = BranchE ? BrTargetE : PCE + 32'd4;

  // A non-branch that IF predicted taken is a stale BTB alias and must redirect.
  always_comb begin
    MispredE = 1'b0;
    if (CPU_RST_N && ValidE) begin
      if (is_branch(BranchTypeE))
        MispredE = (BranchE != PredTakenE) || (BranchE && (PredTargetE != BrTargetE));
      else
        MispredE = PredTakenE;
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      valid_q   <= '0;
      BrCount   <= '0;
      MissCount <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else begin
      if (br_valid) begin
        BrCount <= BrCount + 32'd1;
        if (e_hit) begin
          ctr_q[e_idx] <= ctr_next(ctr_q[e_idx], BranchE);
          if (BranchE) tgt_q[e_idx] <= BrTargetE;
        end else if (BranchE) begin
          valid_q[e_idx] <= 1'b1;
          tag_q[e_idx]   <= e_tag;
          tgt_q[e_idx]   <= BrTargetE;
          ctr_q[e_idx]   <= CTR_WEAK_T;
        end
      end else if (ValidE && PredTakenE && e_hit) begin
        valid_q[e_idx] <= 1'b0;
      end
      if (MispredE) MissCount <= MissCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a per-cycle reference model and literal spot checks.
module tb_branch_predict_unit;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcf;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        valid_e;
  logic [2:0]  type_e;
  logic [31:0] op1, op2, pce, tgt_e, pred_tgt_e;
  logic        pred_tk_e;
  logic        branch_e, mispred_e;
  logic [31:0] redirect_pc, br_count, miss_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.DEPTH(DEPTH), .PRED_EN(1'b1)) dut (
    .CPU_CLK     (clk),
    .CPU_RST_N   (rst_n),
    .PCF         (pcf),
    .PredTakenF  (pred_taken_f),
    .PredTargetF (pred_target_f),
    .ValidE      (valid_e),
    .BranchTypeE (type_e),
    .Operand1    (op1),
    .Operand2    (op2),
    .PCE         (pce),
    .BrTargetE   (tgt_e),
    .PredTakenE  (pred_tk_e),
    .PredTargetE (pred_tgt_e),
    .BranchE     (branch_e),
    .MispredE    (mispred_e),
    .RedirectPCE (redirect_pc),
    .BrCount     (br_count),
    .MissCount   (miss_count)
  );

  // Reference model: a table keyed by word index, holding the owning PC's upper bits.
  bit          m_v   [DEPTH];
  int unsigned m_tag [DEPTH];
  int unsigned m_tgt [DEPTH];
  int          m_ctr [DEPTH];
  int unsigned m_br = 0;
  int unsigned m_miss = 0;

  function automatic int midx(input int unsigned pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic int unsigned mtag(input int unsigned pc);
    return pc / (4 * DEPTH);
  endfunction

  function automatic bit m_isbr(input logic [2:0] t);
    return (t >= 3'd1) && (t <= 3'd6);
  endfunction

  function automatic bit m_outcome(input logic [2:0] t, input int unsigned a, input int unsigned b);
    case (t)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return int'(a) < int'(b);
      3'd4: return a < b;
      3'd5: return int'(a) >= int'(b);
      3'd6: return a >= b;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_v[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  function automatic bit m_misp();
    bit tk;
    if (!rst_n || !valid_e) return 0;
    if (!m_isbr(type_e)) return pred_tk_e;
    tk = m_outcome(type_e, op1, op2);
    return (tk != pred_tk_e) || (tk && (pred_tgt_e != tgt_e));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      bit ptk, btk;
      ptk = rst_n && m_hit(pcf) && (m_ctr[midx(pcf)] >= 2);
      btk = rst_n && valid_e && m_isbr(type_e) && m_outcome(type_e, op1, op2);
      chk("model PredTakenF", {31'd0, pred_taken_f}, {31'd0, ptk});
      chk("model PredTargetF", pred_target_f, ptk ? m_tgt[midx(pcf)] : pcf + 32'd4);
      chk("model BranchE", {31'd0, branch_e}, {31'd0, btk});
      chk("model MispredE", {31'd0, mispred_e}, {31'd0, m_misp()});
      chk("model RedirectPCE", redirect_pc, btk ? tgt_e : pce + 32'd4);
      chk("model BrCount", br_count, m_br);
      chk("model MissCount", miss_count, m_miss);
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
      end
      m_br = 0;
      m_miss = 0;
    end else begin
      int  ix;
      bit  tk;
      ix = midx(pce);
      if (m_misp()) m_miss++;
      if (valid_e && m_isbr(type_e)) begin
        m_br++;
        tk = m_outcome(type_e, op1, op2);
        if (m_hit(pce)) begin
          m_ctr[ix] = tk ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                         : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
          if (tk) m_tgt[ix] = tgt_e;
        end else if (tk) begin
          m_v[ix] = 1; m_tag[ix] = mtag(pce); m_tgt[ix] = tgt_e; m_ctr[ix] = 2;
        end
      end else if (valid_e && pred_tk_e && m_hit(pce)) begin
        m_v[ix] = 0;
      end
    end
  end

  task automatic set_br(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] tg, input logic ptk,
                        input logic [31:0] ptg);
    valid_e = 1; type_e = t; pce = pc; op1 = a; op2 = b; tgt_e = tg;
    pred_tk_e = ptk; pred_tgt_e = ptg;
  endtask

  task automatic set_idle(input logic [31:0] fpc);
    valid_e = 0; pcf = fpc;
  endtask

  task automatic to_neg();
    @(negedge clk); #1;
  endtask

  task automatic to_pos();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; pcf = 32'h100; valid_e = 0; type_e = 3'd0; op1 = 0; op2 = 0;
    pce = 0; tgt_e = 0; pred_tk_e = 0; pred_tgt_e = 0;
    to_pos();
    cmp_on = 1;
    to_neg();
    chk("reset PredTakenF", {31'd0, pred_taken_f}, 32'd0);
    chk("reset PredTargetF", pred_target_f, 32'h104);
    chk("reset BrCount", br_count, 32'd0);
    chk("reset MissCount", miss_count, 32'd0);
    to_pos();
    rst_n = 1;

    // First taken BEQ allocates a weakly-taken entry
    set_br(3'd1, 32'h100, 5, 5, 32'h80, 0, 32'h104);
    to_neg();
    chk("beq BranchE", {31'd0, branch_e}, 32'd1);
    chk("beq MispredE", {31'd0, mispred_e}, 32'd1);
    chk("beq RedirectPCE", redirect_pc, 32'h80);
    to_pos();
    set_idle(32'h100);
    to_neg();
    chk("trained PredTakenF", {31'd0, pred_taken_f}, 32'd1);
    chk("trained PredTargetF", pred_target_f, 32'h80);
    chk("trained BrCount", br_count, 32'd1);
    chk("trained MissCount", miss_count, 32'd1);
    to_pos();

    repeat (2) begin
      set_br(3'd1, 32'h100, 7, 7, 32'h80, 1, 32'h80);
      to_pos();
    end
    set_br(3'd6, 32'h100, 32'h1, 32'hFFFFFFFF, 32'h80, 1, 32'h80);
    to_neg();
    chk("bgeu BranchE", {31'd0, branch_e}, 32'd0);
    chk("bgeu RedirectPCE", redirect_pc, 32'h104);
    to_pos();
    set_idle(32'h100);
    to_neg();
    chk("ctr10 PredTakenF", {31'd0, pred_taken_f}, 32'd1);
    to_pos();
    set_br(3'd6, 32'h100, 32'h1, 32'hFFFFFFFF, 32'h80, 1, 32'h80);
    to_pos();
    set_idle(32'h100);
    to_neg();
    chk("ctr01 PredTakenF", {31'd0, pred_taken_f}, 32'd0);
    chk("ctr01 PredTargetF", pred_target_f, 32'h104);
    to_pos();

    // Signed vs unsigned less-than on the same operands
    set_br(3'd3, 32'h104, 32'hFFFFFFFF, 32'h1, 32'h40, 0, 32'h108);
    to_neg();
    chk("blt BranchE", {31'd0, branch_e}, 32'd1);
    to_pos();
    set_br(3'd4, 32'h104, 32'hFFFFFFFF, 32'h1, 32'h40, 0, 32'h108);
    to_neg();
    chk("bltu BranchE", {31'd0, branch_e}, 32'd0);
    to_pos();

    // Alias at index 0: 0x100 and 0x200 differ only in tag
    set_br(3'd1, 32'h100, 0, 0, 32'h80, 0, 32'h104);
    to_pos();
    set_idle(32'h100);
    to_neg();
    chk("retrain PredTakenF", {31'd0, pred_taken_f}, 32'd1);
    to_pos();
    set_idle(32'h200);
    to_neg();
    chk("alias PredTakenF", {31'd0, pred_taken_f}, 32'd0);
    chk("alias PredTargetF", pred_target_f, 32'h204);
    to_pos();
    set_br(3'd2, 32'h200, 1, 2, 32'h400, 0, 32'h204);
    to_pos();
    set_idle(32'h100);
    to_neg();
    chk("replaced old PredTakenF", {31'd0, pred_taken_f}, 32'd0);
    to_pos();
    set_idle(32'h200);
    to_neg();
    chk("replaced new PredTargetF", pred_target_f, 32'h400);
    to_pos();

    // ValidE=0 must not resolve or train
    set_br(3'd1, 32'h200, 9, 9, 32'h600, 0, 32'h204);
    valid_e = 0;
    to_neg();
    chk("invalid BranchE", {31'd0, branch_e}, 32'd0);
    chk("invalid MispredE", {31'd0, mispred_e}, 32'd0);
    to_pos();

    // Same-cycle lookup and update sees old state
    pcf = 32'h200;
    set_br(3'd2, 32'h200, 3, 3, 32'h400, 1, 32'h400);
    to_neg();
    chk("same-cycle PredTakenF", {31'd0, pred_taken_f}, 32'd1);
    chk("same-cycle PredTargetF", pred_target_f, 32'h400);
    chk("same-cycle MispredE", {31'd0, mispred_e}, 32'd1);
    to_pos();
    set_idle(32'h200);
    to_neg();
    chk("after update PredTakenF", {31'd0, pred_taken_f}, 32'd0);
    to_pos();

    // Predicted-taken non-branch invalidates the entry
    set_br(3'd1, 32'h100, 0, 0, 32'h80, 0, 32'h104);
    to_pos();
    set_br(3'd0, 32'h100, 0, 0, 32'h80, 1, 32'h80);
    pcf = 32'h100;
    to_neg();
    chk("nobranch PredTakenF", {31'd0, pred_taken_f}, 32'd1);
    chk("nobranch BranchE", {31'd0, branch_e}, 32'd0);
    chk("nobranch MispredE", {31'd0, mispred_e}, 32'd1);
    chk("nobranch RedirectPCE", redirect_pc, 32'h104);
    to_pos();
    set_br(3'd7, 32'h100, 1, 1, 32'h80, 0, 32'h104);
    to_neg();
    chk("cleared PredTakenF", {31'd0, pred_taken_f}, 32'd0);
    chk("unknown MispredE", {31'd0, mispred_e}, 32'd0);
    to_pos();

    // Reset after training wipes tables and counters
    set_br(3'd1, 32'h100, 0, 0, 32'h80, 0, 32'h104);
    to_pos();
    rst_n = 0;
    to_neg();
    chk("in-reset BranchE", {31'd0, branch_e}, 32'd0);
    chk("in-reset MispredE", {31'd0, mispred_e}, 32'd0);
    to_pos();
    rst_n = 1;
    set_idle(32'h100);
    to_neg();
    chk("post-reset PredTakenF 100", {31'd0, pred_taken_f}, 32'd0);
    chk("post-reset BrCount", br_count, 32'd0);
    chk("post-reset MissCount", miss_count, 32'd0);
    to_pos();
    set_idle(32'h104);
    to_neg();
    chk("post-reset PredTakenF 104", {31'd0, pred_taken_f}, 32'd0);
    to_pos();

    cmp_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
